// File: rtl/spike_rate_encoder_if.sv
// Handshake and output bundle between the stimulus host and the spike rate encoder.
interface spike_rate_encoder_if #(
  parameter int unsigned INT_W = 8,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic [INT_W-1:0] intensity;
  logic             ready;
  logic             busy;
  logic             spike_out;
  logic             done;
  logic [CNT_W-1:0] spike_count;

  modport master (
    output start, intensity,
    input  ready, busy, spike_out, done, spike_count
  );

  modport slave (
    input  start, intensity,
    output ready, busy, spike_out, done, spike_count
  );
endinterface

// File: rtl/spike_rate_encoder.sv
// Rate-codes an intensity sample into a spike train over WINDOW cycles using a
// phase accumulator that fires on overflow, with an optional refractory gap.
module spike_rate_encoder #(
  parameter int unsigned INT_W   = 8,
  parameter int unsigned WINDOW  = 256,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned REFRACT = 0
) (
  input logic              clk,
  input logic              rst,
  spike_rate_encoder_if.slave bus
);
  localparam int unsigned RW = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [INT_W-1:0] i_lat;
  logic [INT_W-1:0] acc;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] spike_count;
  logic [RW-1:0]    refr_cnt;
  logic             spike_out;
  logic [INT_W:0]   sum;
  logic             carry;
  logic             last;
  logic             ready;
  logic             busy;
  logic             done;

  assign sum   = {1'b0, acc} + {1'b0, i_lat};
  assign carry = sum[INT_W];
  assign last  = (win_cnt == CNT_W'(WINDOW - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    busy  = (state == RUN) || (state == DONE);
    done  = (state == DONE);
  end

  // The accumulator always keeps the wrapped residue, so a carry swallowed by
  // the refractory gap still advances the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_lat       <= '0;
      acc         <= '0;
      win_cnt     <= '0;
      refr_cnt    <= '0;
      spike_count <= '0;
      spike_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          spike_out <= 1'b0;
          if (bus.start) begin
            i_lat       <= bus.intensity;
            acc         <= '0;
            win_cnt     <= '0;
            refr_cnt    <= '0;
            spike_count <= '0;
          end
        end
        RUN: begin
          acc <= sum[INT_W-1:0];
          if (carry && (refr_cnt == '0)) begin
            spike_out   <= 1'b1;
            spike_count <= spike_count + CNT_W'(1);
            refr_cnt    <= RW'(REFRACT);
          end else begin
            spike_out <= 1'b0;
            if (refr_cnt != '0) refr_cnt <= refr_cnt - RW'(1);
          end
          if (!last) win_cnt <= win_cnt + CNT_W'(1);
        end
        default: spike_out <= 1'b0;
      endcase
    end
  end

  assign bus.ready       = ready;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.spike_out   = spike_out;
  assign bus.spike_count = spike_count;
endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder: default, refractory and short-window instances.
module tb_spike_rate_encoder;
  logic clk;
  logic rst;
  int unsigned total;
  int unsigned bad;

  spike_rate_encoder_if #(.INT_W(8), .CNT_W(16)) b0 ();
  spike_rate_encoder_if #(.INT_W(8), .CNT_W(16)) b1 ();
  spike_rate_encoder_if #(.INT_W(8), .CNT_W(16)) b2 ();

  spike_rate_encoder #(.INT_W(8), .WINDOW(256), .CNT_W(16), .REFRACT(0)) u_def (
    .clk(clk), .rst(rst), .bus(b0.slave));
  spike_rate_encoder #(.INT_W(8), .WINDOW(256), .CNT_W(16), .REFRACT(1)) u_ref (
    .clk(clk), .rst(rst), .bus(b1.slave));
  spike_rate_encoder #(.INT_W(8), .WINDOW(10), .CNT_W(16), .REFRACT(0)) u_short (
    .clk(clk), .rst(rst), .bus(b2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    total++; if (b0.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", b0.ready); end
    total++; if (b0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", b0.busy); end
    total++; if (b0.spike_out !== 1'b0) begin bad++; $display("FAIL reset_spike got=%b want=0", b0.spike_out); end
    total++; if (b0.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", b0.done); end
    total++; if (b0.spike_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", b0.spike_count); end
    total++; if (b1.ready !== 1'b1 || b2.ready !== 1'b1) begin bad++; $display("FAIL reset_ready_others got=%b%b want=11", b1.ready, b2.ready); end
  endtask

  task automatic test_half_rate;
    int unsigned dones;
    logic exp;
    dones = 0;
    b0.intensity = 8'd128; b0.start = 1'b1; tick; b0.start = 1'b0;
    for (int k = 0; k < 256; k++) begin
      tick;
      exp = (k % 2 == 1);
      total++; if (b0.spike_out !== exp) begin bad++; $display("FAIL half_spike k=%0d got=%b want=%b", k, b0.spike_out, exp); end
      if (b0.done === 1'b1) dones++;
    end
    total++; if (b0.done !== 1'b1) begin bad++; $display("FAIL half_done_last got=%b want=1", b0.done); end
    total++; if (dones != 1) begin bad++; $display("FAIL half_done_pulses got=%0d want=1", dones); end
    total++; if (b0.spike_count !== 16'd128) begin bad++; $display("FAIL half_count got=%0d want=128", b0.spike_count); end
    tick;
    total++; if (b0.ready !== 1'b1 || b0.done !== 1'b0 || b0.spike_out !== 1'b0) begin
      bad++; $display("FAIL half_idle got ready=%b done=%b spike=%b want 1 0 0", b0.ready, b0.done, b0.spike_out); end
    total++; if (b0.spike_count !== 16'd128) begin bad++; $display("FAIL half_hold got=%0d want=128", b0.spike_count); end
  endtask

  task automatic test_back_to_back;
    b0.intensity = 8'd0; b0.start = 1'b1; tick; b0.start = 1'b0;
    for (int k = 0; k < 256; k++) begin
      tick;
      total++; if (b0.spike_out !== 1'b0) begin bad++; $display("FAIL zero_spike k=%0d got=%b want=0", k, b0.spike_out); end
    end
    total++; if (b0.done !== 1'b1 || b0.spike_count !== 16'd0) begin
      bad++; $display("FAIL zero_end got done=%b count=%0d want 1 0", b0.done, b0.spike_count); end
    tick;
    total++; if (b0.ready !== 1'b1 || b0.spike_count !== 16'd0) begin
      bad++; $display("FAIL b2b_idle got ready=%b count=%0d want 1 0", b0.ready, b0.spike_count); end
    b0.intensity = 8'd255; b0.start = 1'b1; tick; b0.start = 1'b0;
    total++; if (b0.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got busy=%b want=1", b0.busy); end
    for (int k = 0; k < 256; k++) begin
      tick;
      if (k == 0) begin
        total++; if (b0.spike_out !== 1'b0) begin bad++; $display("FAIL full_k0 got=%b want=0", b0.spike_out); end
      end else if (k == 1) begin
        total++; if (b0.spike_out !== 1'b1) begin bad++; $display("FAIL full_k1 got=%b want=1", b0.spike_out); end
      end
    end
    total++; if (b0.done !== 1'b1 || b0.spike_count !== 16'd255) begin
      bad++; $display("FAIL full_end got done=%b count=%0d want 1 255", b0.done, b0.spike_count); end
    tick;
  endtask

  task automatic test_refractory;
    logic exp;
    b1.intensity = 8'd255; b1.start = 1'b1; tick; b1.start = 1'b0;
    for (int k = 0; k < 256; k++) begin
      tick;
      exp = (k % 2 == 1);
      total++; if (b1.spike_out !== exp) begin bad++; $display("FAIL refr_spike k=%0d got=%b want=%b", k, b1.spike_out, exp); end
    end
    total++; if (b1.done !== 1'b1 || b1.spike_count !== 16'd128) begin
      bad++; $display("FAIL refr_end got done=%b count=%0d want 1 128", b1.done, b1.spike_count); end
    tick;
  endtask

  task automatic test_start_ignored;
    int unsigned not_ready;
    not_ready = 0;
    b0.intensity = 8'd200; b0.start = 1'b1; tick; b0.start = 1'b0;
    for (int k = 0; k < 256; k++) begin
      tick;
      if (b0.ready !== 1'b1 && b0.busy === 1'b1) not_ready++;
      if (k == 50) begin b0.start = 1'b1; b0.intensity = 8'd10; end
      if (k == 51) b0.start = 1'b0;
    end
    total++; if (not_ready != 256) begin bad++; $display("FAIL ign_ready_low got=%0d want=256", not_ready); end
    total++; if (b0.done !== 1'b1 || b0.spike_count !== 16'd200) begin
      bad++; $display("FAIL ign_end got done=%b count=%0d want 1 200", b0.done, b0.spike_count); end
    tick;
    total++; if (b0.ready !== 1'b1) begin bad++; $display("FAIL ign_idle got=%b want=1", b0.ready); end
  endtask

  task automatic test_mid_reset;
    int unsigned dones;
    b0.intensity = 8'd128; b0.start = 1'b1; tick; b0.start = 1'b0;
    for (int k = 0; k < 100; k++) tick;
    rst = 1'b1; tick; rst = 1'b0;
    total++; if (b0.ready !== 1'b1 || b0.busy !== 1'b0 || b0.spike_out !== 1'b0 || b0.done !== 1'b0 || b0.spike_count !== 16'd0) begin
      bad++; $display("FAIL rst_outputs got ready=%b busy=%b spike=%b done=%b count=%0d want 1 0 0 0 0",
                      b0.ready, b0.busy, b0.spike_out, b0.done, b0.spike_count); end
    dones = 0;
    for (int k = 0; k < 200; k++) begin
      tick;
      if (b0.done === 1'b1 || b0.busy === 1'b1) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL rst_no_done got=%0d want=0", dones); end
    b0.intensity = 8'd64; b0.start = 1'b1; tick; b0.start = 1'b0;
    for (int k = 0; k < 256; k++) begin
      tick;
      if (b0.done === 1'b1) dones++;
    end
    total++; if (dones != 1 || b0.spike_count !== 16'd64) begin
      bad++; $display("FAIL rst_restart got dones=%0d count=%0d want 1 64", dones, b0.spike_count); end
    tick;
  endtask

  task automatic test_short_window;
    int unsigned idx;
    logic [11:0] pat;
    pat = 12'b1001_0010_0000;
    b2.intensity = 8'd77; b2.start = 1'b1; tick; b2.start = 1'b0;
    idx = 1;
    total++; if (b2.spike_out !== pat[idx]) begin bad++; $display("FAIL short_spike idx=%0d got=%b want=%b", idx, b2.spike_out, pat[idx]); end
    while (b2.done !== 1'b1 && idx < 11) begin
      tick;
      idx++;
      total++; if (b2.spike_out !== pat[idx]) begin bad++; $display("FAIL short_spike idx=%0d got=%b want=%b", idx, b2.spike_out, pat[idx]); end
    end
    total++; if (idx != 11 || b2.done !== 1'b1) begin
      bad++; $display("FAIL short_len got cycle=%0d done=%b want 11 1", idx, b2.done); end
    total++; if (b2.spike_count !== 16'd3) begin bad++; $display("FAIL short_count got=%0d want=3", b2.spike_count); end
    tick;
    total++; if (b2.ready !== 1'b1 || b2.done !== 1'b0) begin
      bad++; $display("FAIL short_idle got ready=%b done=%b want 1 0", b2.ready, b2.done); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    b0.start = 1'b0; b0.intensity = '0;
    b1.start = 1'b0; b1.intensity = '0;
    b2.start = 1'b0; b2.intensity = '0;
    tick; tick;
    rst = 1'b0;
    test_reset;
    test_half_rate;
    test_back_to_back;
    test_refractory;
    test_start_ignored;
    test_mid_reset;
    test_short_window;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
